// File: rtl/vga_fb_reader_if.sv
// vga_fb_reader_if: framebuffer RAM port plus front/back swap handshake between reader and producer
interface vga_fb_reader_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 8
) ();
    logic [ADDR_W:0]   fb_addr_o;
    logic [PIX_W-1:0]  fb_data_i;
    logic              swap_req;
    logic              swap_ack;
    logic              front_sel;
    modport master (output fb_addr_o, swap_ack, front_sel, input fb_data_i, swap_req);
    modport slave  (input fb_addr_o, swap_ack, front_sel, output fb_data_i, swap_req);
endinterface

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: 320x240 RGB332 double-buffered framebuffer scan-out, pixel-doubled to 640x480, 3-clk pixel/sync latency
// Optional white 1-pixel screen border when VGA_BORDER_EN is defined.
`ifndef WIDTH
`define WIDTH 10
`endif
module vga_fb_reader #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [`WIDTH-1:0] x_i,
    input  logic [`WIDTH-1:0] y_i,
    input  logic              video_on_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    output logic [11:0]       rgb_o,
    output logic              hsync_o,
    output logic              vsync_o,
    vga_fb_reader_if.master   fb
);
    typedef enum logic [1:0] {IDLE, PENDING, WAIT_REL} state_t;

    state_t            state_q;
    logic              front_q, ack_q;
    logic [ADDR_W:0]   addr_q;
    logic [11:0]       rgb_q;
    logic [2:0]        von_q, hs_q, vs_q;
    logic [ADDR_W-1:0] xh_d, yh_d, idx_d;
    logic [11:0]       pix_d, rgb_d;
    logic              vs_rise;

    // y*320 as (y<<8)+(y<<6); idle address 0 outside the active area
    assign xh_d    = ADDR_W'(x_i >> 1);
    assign yh_d    = ADDR_W'(y_i >> 1);
    assign idx_d   = video_on_i ? (yh_d << 8) + (yh_d << 6) + xh_d : '0;
    assign pix_d   = {fb.fb_data_i[7:5], fb.fb_data_i[7], fb.fb_data_i[4:2], fb.fb_data_i[4],
                      fb.fb_data_i[1:0], fb.fb_data_i[1:0]};
    assign vs_rise = vsync_i & ~vs_q[0];

`ifdef VGA_BORDER_EN
    logic [2:0] bd_q;
    logic       bd_d;
    assign bd_d  = (x_i == `WIDTH'(0)) || (x_i == `WIDTH'(639)) || (y_i == `WIDTH'(0)) || (y_i == `WIDTH'(479));
    assign rgb_d = von_q[1] ? (bd_q[1] ? 12'hFFF : pix_d) : 12'h000;
    // border flag rides alongside the pixel through the same pipeline depth
    always_ff @(posedge clk or posedge reset)
        if (reset) bd_q <= '0;
        else       bd_q <= {bd_q[1:0], bd_d};
`else
    assign rgb_d = von_q[1] ? pix_d : 12'h000;
`endif

    // address issue, RAM-data capture into the DAC register, and sync delay lines
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            addr_q <= '0;
            rgb_q  <= '0;
            von_q  <= '0;
            hs_q   <= '0;
            vs_q   <= '0;
        end else begin
            addr_q <= {front_q, idx_d};
            rgb_q  <= rgb_d;
            von_q  <= {von_q[1:0], video_on_i};
            hs_q   <= {hs_q[1:0], hsync_i};
            vs_q   <= {vs_q[1:0], vsync_i};
        end

    // swap handshake: a request is honoured only at the next vsync rise, once per request
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            front_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE:     if (fb.swap_req) state_q <= PENDING;
                PENDING:  if (vs_rise) begin
                              front_q <= ~front_q;
                              ack_q   <= 1'b1;
                              state_q <= WAIT_REL;
                          end else if (!fb.swap_req) state_q <= IDLE;
                WAIT_REL: if (!fb.swap_req) state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end

    assign fb.fb_addr_o = addr_q;
    assign fb.swap_ack  = ack_q;
    assign fb.front_sel = front_q;
    assign rgb_o        = rgb_q;
    assign hsync_o      = hs_q[2];
    assign vsync_o      = vs_q[2];
endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader: directed + random scan-out checks against a frame-level reference model
`ifndef WIDTH
`define WIDTH 10
`endif
module tb_vga_fb_reader;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [`WIDTH-1:0] x_i = '0, y_i = '0;
    logic              video_on_i = 1'b0, hsync_i = 1'b0, vsync_i = 1'b0;
    logic [11:0]       rgb_o;
    logic              hsync_o, vsync_o;
    int                compared = 0, mismatched = 0;
    bit                front_m = 1'b0;
    int                hw;

    typedef struct {
        logic [17:0] a;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;
    exp_t q[$];

`ifdef VGA_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    vga_fb_reader_if fb ();

    vga_fb_reader dut (
        .clk(clk), .reset(reset), .x_i(x_i), .y_i(y_i), .video_on_i(video_on_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .rgb_o(rgb_o), .hsync_o(hsync_o),
        .vsync_o(vsync_o), .fb(fb)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_f(input logic [17:0] a);
        if (a[16:0] == 17'd322)   return 8'hE0;
        if (a[16:0] == 17'd32000) return 8'h00;
        return 8'(a ^ (a >> 5) ^ ((a >> 17) * 18'hA5));
    endfunction

    always @(posedge clk) fb.fb_data_i <= ram_f(fb.fb_addr_o);

    function automatic logic [11:0] exp12(input logic [7:0] d);
        int r = int'(d[7:5]), g = int'(d[4:2]), b = int'(d[1:0]);
        return {4'(r * 2 + r / 4), 4'(g * 2 + g / 4), 4'(b * 5)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int x, input int y, input bit von, input bit hs, input bit vs);
        exp_t e;
        int   idx;
        bit   bd;
        if (q.size() >= 1) chk("addr", 32'(fb.fb_addr_o), 32'(q[q.size()-1].a));
        if (q.size() >= 3) begin
            chk("rgb", 32'(rgb_o), 32'(q[q.size()-3].rgb));
            chk("hsync", 32'(hsync_o), 32'(q[q.size()-3].hs));
            chk("vsync", 32'(vsync_o), 32'(q[q.size()-3].vs));
        end
        x_i = `WIDTH'(x); y_i = `WIDTH'(y); video_on_i = von; hsync_i = hs; vsync_i = vs;
        fb.swap_req = 1'b0;
        idx = von ? (y / 2) * 320 + x / 2 : 0;
        bd = BORDER && (x == 0 || x == 639 || y == 0 || y == 479);
        e.a = {front_m, 17'(idx)};
        e.rgb = !von ? 12'h000 : bd ? 12'hFFF : exp12(ram_f(e.a));
        e.hs = hs;
        e.vs = vs;
        q.push_back(e);
        if (q.size() > 3) void'(q.pop_front());
        @(negedge clk);
    endtask

    task automatic tick(input bit sr, input bit vs);
        fb.swap_req = sr;
        vsync_i = vs;
        @(negedge clk);
    endtask

    initial begin
        fb.swap_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rgb", 32'(rgb_o), 0);
        chk("rst_addr", 32'(fb.fb_addr_o), 0);
        chk("rst_front", 32'(fb.front_sel), 0);
        chk("rst_ack", 32'(fb.swap_ack), 0);
        reset = 1'b0;
        tick(0, 0);
        tick(1, 0); chk("t5_pend_ack", 32'(fb.swap_ack), 0); chk("t5_pend_front", 32'(fb.front_sel), 0);
        tick(1, 0); tick(1, 0); chk("t5_wait_ack", 32'(fb.swap_ack), 0);
        tick(1, 1); chk("t5_ack", 32'(fb.swap_ack), 1); chk("t5_front", 32'(fb.front_sel), 1);
        tick(1, 1); chk("t5_ack_pulse", 32'(fb.swap_ack), 0); chk("t5_front_hold", 32'(fb.front_sel), 1);
        tick(1, 0); tick(1, 1); chk("t5_no_second", 32'(fb.swap_ack), 0); chk("t5_front_once", 32'(fb.front_sel), 1);
        tick(0, 0); tick(0, 0);
        tick(1, 0); tick(0, 0); tick(0, 1);
        chk("t6_ack", 32'(fb.swap_ack), 0); chk("t6_front", 32'(fb.front_sel), 1);
        tick(0, 0);
        tick(1, 1); chk("same_clk_ack", 32'(fb.swap_ack), 0); chk("same_clk_front", 32'(fb.front_sel), 1);
        tick(1, 1); tick(1, 0);
        tick(1, 1); chk("next_frame_ack", 32'(fb.swap_ack), 1); chk("next_frame_front", 32'(fb.front_sel), 0);
        tick(0, 0); tick(1, 0); tick(1, 1); chk("swap2_front", 32'(fb.front_sel), 1);
        tick(0, 0); tick(1, 0);
        x_i = `WIDTH'(100); y_i = `WIDTH'(50); video_on_i = 1'b1; hsync_i = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_hsync", 32'(hsync_o), 1);
        #2 reset = 1'b1;
        #1;
        chk("t1_rgb", 32'(rgb_o), 0);
        chk("t1_hsync", 32'(hsync_o), 0);
        chk("t1_addr", 32'(fb.fb_addr_o), 0);
        chk("t1_front", 32'(fb.front_sel), 0);
        chk("t1_ack", 32'(fb.swap_ack), 0);
        fb.swap_req = 1'b0; vsync_i = 1'b0; video_on_i = 1'b0; hsync_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick(0, 1); chk("t1_idle_ack", 32'(fb.swap_ack), 0); chk("t1_idle_front", 32'(fb.front_sel), 0);
        tick(0, 0); tick(1, 0); tick(1, 1); chk("t1_fresh_swap", 32'(fb.front_sel), 1);
        tick(0, 0);
        front_m = 1'b1;
        q.delete();
        step(5, 3, 1, 0, 0); chk("t2_addr", 32'(fb.fb_addr_o), 32'({front_m, 17'd322}));
        step(5, 3, 0, 0, 0); step(0, 0, 0, 0, 0); chk("t2_rgb", 32'(rgb_o), 32'h0F00);
        step(639, 479, 1, 0, 0); chk("t3_addr", 32'(fb.fb_addr_o), 32'({front_m, 17'd76799}));
        step(639, 479, 0, 0, 0); chk("t3_off_addr", 32'(fb.fb_addr_o), 32'({front_m, 17'd0}));
        step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0); chk("t3_off_rgb", 32'(rgb_o), 0);
        step(0, 200, 1, 0, 0); step(1, 200, 0, 0, 0); step(0, 0, 0, 0, 0);
        chk("border", 32'(rgb_o), BORDER ? 32'hFFF : 32'h0);
        hw = 0;
        for (int i = 0; i < 204; i++) begin
            step(i * 3 % 640, 10, 1, i >= 4 && i < 196, 0);
            if (hsync_o) hw++;
        end
        chk("t4_width", 32'(hw), 192);
        repeat (400)
            step(int'($urandom_range(639, 0)), int'($urandom_range(479, 0)),
                 ($urandom % 8) != 0, $urandom % 2 == 1, $urandom % 2 == 1);
        repeat (3) step(0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
